memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory-access stage of the 5-stage RV64 core; feeds write_back_stage directly.
//  Accepts one instruction at a time from EX/MEM and issues loads/stores to the data cache over a req/done handshake.
//  Aligns and extends load data, and generates store byte strobes.
//  Holds the MEM/WB pipeline register: every output except o_ready/o_mem_* is registered.
// PARAMETERS
//  ADDR_WIDTH  64  byte address width
//  DATA_WIDTH  64  data path width; 8 byte lanes
//  REG_ADDR_W  5   register-file index width
// PORTS
//  i_clk          in   1    clock; all state updates on rising edge
//  i_rst          in   1    synchronous, active-high reset
//  i_valid        in   1    EX/MEM holds a valid instruction
//  o_ready        out  1    stage can accept; =1 only in IDLE (combinational)
//  i_alu_result   in   64   effective address / ALU result
//  i_write_data   in   64   store data (rs2), right-aligned
//  i_func3        in   3    access size/sign (RV func3 encoding)
//  i_mem_re       in   1    load
//  i_mem_we       in   1    store
//  i_pc_plus4, i_pc_target, i_imm_ext  in  64  pass-through
//  i_rd_addr      in   5    pass-through
//  i_result_src   in   3    pass-through
//  i_reg_we       in   1    pass-through (gated by o_valid)
//  o_mem_req      out  1    cache request; held high in BUSY
//  o_mem_we       out  1    request is a store
//  o_mem_addr     out  64   doubleword-aligned address (addr[2:0]=0)
//  o_mem_wdata    out  64   store data shifted to its lane
//  o_mem_wstrb    out  8    byte strobes
//  i_mem_done     in   1    cache completed request; i_mem_rdata valid same cycle
//  i_mem_rdata    in   64   raw doubleword
//  o_valid        out  1    one-cycle pulse per retired instruction
//  o_read_data, o_alu_result, o_pc_plus4, o_pc_target, o_imm_ext  out  64  to write-back
//  o_rd_addr      out  5;   o_result_src  out  3;   o_reg_we  out  1  (=i_reg_we & o_valid)
//  o_misaligned   out  1    misaligned-access pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb = 0.
//  Accept: i_valid & o_ready at an edge.
//  Non-memory op: payload into MEM/WB reg at that edge; o_valid=1 next cycle; latency 1; stays IDLE.
//  Load/store op: latch addr/func3/data/payload at accept; go to BUSY. o_mem_* driven from latched values while BUSY.
//  BUSY: o_ready=0; o_valid=0; wait for i_mem_done.
//  On i_mem_done edge: MEM/WB reg loaded (o_read_data = extracted load, 0 for stores); o_valid=1 next cycle; back to IDLE.
//  Latency = 1 + cache cycles + 1. No back-to-back accept: the accept cycle after done is the IDLE cycle.
//  i_mem_done in IDLE is ignored. i_mem_re & i_mem_we both set: treated as store.
//  Offset off=addr[2:0]. Strobes:
//   sb=8'h01<<off; sh=8'h03<<off; sw=8'h0F<<off; sd=8'hFF.
//   wdata = i_write_data << 8*off.
//  Load: r = rdata >> 8*off; bytes shifted in from above lane 7 are zero. Extension by func3:
//   000 sext8; 001 sext16; 010 sext32; 011 as-is; 100 zext8; 101 zext16; 110 zext32; 111 -> 0.
//  Reset mid-BUSY: return to IDLE next edge; o_mem_req=0; the instruction is dropped; a late done is ignored.
// CONFIGURATION
//  MEMORY_STAGE_MISALIGN_TRAP_EN defined:
//   - Misaligned = (h & off[0]) | (w & off[1:0]!=0) | (d & off!=0).
//   - A misaligned load/store issues no request and stays IDLE.
//   - Next cycle: o_valid=1, o_misaligned=1, o_reg_we=0, o_read_data=0.
//  Not defined: o_misaligned tied 0; no check. Accesses crossing the doubleword follow the zero-fill rule above.
// STRUCTURE
//  memory_stage_pkg:
//   - state enum {IDLE, BUSY}
//   - func3 localparams (LB..LWU)
//   - function wstrb_gen(func3, off)
//  Sub-module load_data_extend (combinational: rdata, off, func3 -> 64-bit result). Everything else stays in this module.
// TESTING
//  1 ALU op, result 64'h1234 -> o_valid pulse 1 cycle later; o_alu_result=64'h1234; o_reg_we=i_reg_we.
//  2 lb addr 0x..03, rdata 64'h0000_0000_80FF_0000, done after 3 cycles -> o_read_data=64'hFFFF_FFFF_FFFF_FF80; o_valid 5 cycles after accept.
//  3 sh addr 0x..06, data 64'hBEEF -> o_mem_wstrb=8'hC0; o_mem_wdata=64'hBEEF_0000_0000_0000; o_mem_addr[2:0]=0.
//  4 lwu addr 0x..04, rdata 64'hF000_0001_xxxx_xxxx -> o_read_data=64'h0000_0000_F000_0001.
//  5 i_rst asserted in BUSY, then i_mem_done asserted -> IDLE; o_mem_req=0; no o_valid pulse.
//  6 (MISALIGN_TRAP_EN) lw addr 0x..02 -> no o_mem_req; o_valid=o_misaligned=1 next cycle; o_reg_we=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types and helpers for the MEM stage: FSM state, RV load/store func3 codes,
// store byte-strobe generation and the natural-alignment check for the trap build.
package memory_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Strobes that would spill past lane 7 are simply truncated.
    function automatic logic [7:0] wstrb_gen(input logic [2:0] func3, input logic [2:0] off);
        logic [7:0] strb;
        case (func3[1:0])
            2'b00:   strb = 8'h01 << off;
            2'b01:   strb = 8'h03 << off;
            2'b10:   strb = 8'h0F << off;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [2:0] off);
        logic mis;
        case (func3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off[1:0] != 2'b00);
            2'b11:   mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_load_data_extend.sv
// Combinational load alignment: shifts the raw doubleword down by the byte offset
// (zero-filling from above lane 7) and sign/zero-extends according to func3.
import memory_stage_pkg::*;

module load_data_extend (
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  func3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        result = '0;
        case (func3)
            LB:      result = {{56{shifted[7]}},  shifted[7:0]};
            LH:      result = {{48{shifted[15]}}, shifted[15:0]};
            LW:      result = {{32{shifted[31]}}, shifted[31:0]};
            LD:      result = shifted;
            LBU:     result = {56'd0, shifted[7:0]};
            LHU:     result = {48'd0, shifted[15:0]};
            LWU:     result = {32'd0, shifted[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage + MEM/WB register: ALU ops retire 1 cycle after accept, memory ops after 1 + cache cycles + 1.
// o_ready is high only in IDLE, so one instruction at a time; MEMORY_STAGE_MISALIGN_TRAP_EN enables the misalignment trap.
import memory_stage_pkg::*;

module memory_stage #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [ADDR_WIDTH-1:0]   i_alu_result,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [2:0]              i_func3,
    input  logic                    i_mem_re,
    input  logic                    i_mem_we,
    input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]   i_pc_target,
    input  logic [DATA_WIDTH-1:0]   i_imm_ext,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr,
    input  logic [2:0]              i_result_src,
    input  logic                    i_reg_we,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_done,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic [ADDR_WIDTH-1:0]   o_alu_result,
    output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]   o_pc_target,
    output logic [DATA_WIDTH-1:0]   o_imm_ext,
    output logic [REG_ADDR_W-1:0]   o_rd_addr,
    output logic [2:0]              o_result_src,
    output logic                    o_reg_we,
    output logic                    o_misaligned
);

    state_t state, state_nxt;

    logic accept;
    logic is_mem;
    logic trap;
    logic retire_direct;
    logic retire_mem;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_func3;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_store;
    logic [ADDR_WIDTH-1:0] lat_pc_plus4;
    logic [ADDR_WIDTH-1:0] lat_pc_target;
    logic [DATA_WIDTH-1:0] lat_imm;
    logic [REG_ADDR_W-1:0] lat_rd;
    logic [2:0]            lat_rsrc;
    logic                  lat_reg_we;

    logic [63:0] ext_data;

    assign accept = i_valid & o_ready;
    assign is_mem = i_mem_re | i_mem_we;

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = is_mem & is_misaligned(i_func3, i_alu_result[2:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept & trap;
        end
    end

    assign o_misaligned = mis_q;
`else
    assign trap         = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // A trapped access retires like an ALU op: no cache request, no BUSY.
    assign retire_direct = accept & (~is_mem | trap);
    assign retire_mem    = (state == BUSY) & i_mem_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !trap) state_nxt = BUSY;
            BUSY:    if (i_mem_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        case (state)
            IDLE: o_ready = 1'b1;
            BUSY: begin
                o_mem_req   = 1'b1;
                o_mem_we    = lat_store;
                o_mem_addr  = {lat_addr[ADDR_WIDTH-1:3], 3'b000};
                o_mem_wdata = lat_wdata << {lat_addr[2:0], 3'b000};
                o_mem_wstrb = lat_store ? wstrb_gen(lat_func3, lat_addr[2:0]) : '0;
            end
            default: o_ready = 1'b0;
        endcase
    end

    // Loads with both re and we set are treated as stores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_addr      <= '0;
            lat_func3     <= '0;
            lat_wdata     <= '0;
            lat_store     <= 1'b0;
            lat_pc_plus4  <= '0;
            lat_pc_target <= '0;
            lat_imm       <= '0;
            lat_rd        <= '0;
            lat_rsrc      <= '0;
            lat_reg_we    <= 1'b0;
        end else if (accept && is_mem) begin
            lat_addr      <= i_alu_result;
            lat_func3     <= i_func3;
            lat_wdata     <= i_write_data;
            lat_store     <= i_mem_we;
            lat_pc_plus4  <= i_pc_plus4;
            lat_pc_target <= i_pc_target;
            lat_imm       <= i_imm_ext;
            lat_rd        <= i_rd_addr;
            lat_rsrc      <= i_result_src;
            lat_reg_we    <= i_reg_we;
        end
    end

    load_data_extend u_load_data_extend (
        .rdata  (i_mem_rdata),
        .off    (lat_addr[2:0]),
        .func3  (lat_func3),
        .result (ext_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_reg_we     <= 1'b0;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_pc_plus4   <= '0;
            o_pc_target  <= '0;
            o_imm_ext    <= '0;
            o_rd_addr    <= '0;
            o_result_src <= '0;
        end else begin
            o_valid  <= retire_direct | retire_mem;
            o_reg_we <= retire_direct ? (i_reg_we & ~trap) :
                        retire_mem    ? lat_reg_we : 1'b0;
            if (retire_direct) begin
                o_read_data  <= '0;
                o_alu_result <= i_alu_result;
                o_pc_plus4   <= i_pc_plus4;
                o_pc_target  <= i_pc_target;
                o_imm_ext    <= i_imm_ext;
                o_rd_addr    <= i_rd_addr;
                o_result_src <= i_result_src;
            end else if (retire_mem) begin
                o_read_data  <= lat_store ? '0 : ext_data;
                o_alu_result <= lat_addr;
                o_pc_plus4   <= lat_pc_plus4;
                o_pc_target  <= lat_pc_target;
                o_imm_ext    <= lat_imm;
                o_rd_addr    <= lat_rd;
                o_result_src <= lat_rsrc;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected MEM/WB contents are queued at issue
// and popped when o_valid pulses; latency and cache-port values are checked per scenario.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready;
    logic [63:0] i_alu_result, i_write_data, i_pc_plus4, i_pc_target, i_imm_ext;
    logic [2:0]  i_func3, i_result_src;
    logic        i_mem_re, i_mem_we, i_reg_we;
    logic [4:0]  i_rd_addr;
    logic        o_mem_req, o_mem_we;
    logic [63:0] o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic        i_mem_done;
    logic [63:0] i_mem_rdata;
    logic        o_valid;
    logic [63:0] o_read_data, o_alu_result, o_pc_plus4, o_pc_target, o_imm_ext;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic        o_reg_we, o_misaligned;

    always #5 clk = ~clk;

    memory_stage dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_func3(i_func3),
        .i_mem_re(i_mem_re), .i_mem_we(i_mem_we), .i_pc_plus4(i_pc_plus4),
        .i_pc_target(i_pc_target), .i_imm_ext(i_imm_ext), .i_rd_addr(i_rd_addr),
        .i_result_src(i_result_src), .i_reg_we(i_reg_we),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_done(i_mem_done), .i_mem_rdata(i_mem_rdata),
        .o_valid(o_valid), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
        .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target), .o_imm_ext(o_imm_ext),
        .o_rd_addr(o_rd_addr), .o_result_src(o_result_src), .o_reg_we(o_reg_we),
        .o_misaligned(o_misaligned)
    );

    typedef struct packed {
        logic [63:0] read_data;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [63:0] pc_target;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [2:0]  rsrc;
        logic        reg_we;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  f3;
        logic [63:0] rdat;
        logic [63:0] expv;
    } ld_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  f3;
        logic [63:0] wdat;
        logic [7:0]  strb;
        logic [63:0] lane;
    } st_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk_exp(input logic [63:0] addr, input logic [63:0] rdat,
                                    input logic [4:0] rd, input logic rwe, input logic mis);
        exp_t e;
        e.read_data = rdat;
        e.alu       = addr;
        e.pc4       = addr + 64'd4;
        e.pc_target = addr + 64'h100;
        e.imm       = addr ^ 64'hA5A5;
        e.rd        = rd;
        e.rsrc      = rd[2:0];
        e.reg_we    = rwe;
        e.mis       = mis;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g.read_data = o_read_data;
        g.alu       = o_alu_result;
        g.pc4       = o_pc_plus4;
        g.pc_target = o_pc_target;
        g.imm       = o_imm_ext;
        g.rd        = o_rd_addr;
        g.rsrc      = o_result_src;
        g.reg_we    = o_reg_we;
        g.mis       = o_misaligned;
        return g;
    endfunction

    // Drives one instruction for a single cycle, starting at a falling edge.
    task automatic issue(input logic [63:0] addr, input logic [63:0] wdat, input logic [2:0] f3,
                         input logic re, input logic we, input logic rwe, input logic [4:0] rd);
        i_alu_result = addr;
        i_write_data = wdat;
        i_func3      = f3;
        i_mem_re     = re;
        i_mem_we     = we;
        i_reg_we     = rwe;
        i_rd_addr    = rd;
        i_result_src = rd[2:0];
        i_pc_plus4   = addr + 64'd4;
        i_pc_target  = addr + 64'h100;
        i_imm_ext    = addr ^ 64'hA5A5;
        i_valid      = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
        i_mem_re = 1'b0;
        i_mem_we = 1'b0;
    endtask

    // Cache model: done in the ncache-th BUSY cycle; lat counts cycles with the accept cycle as 1.
    task automatic run_mem(input int ncache, input logic [63:0] rdat, output int lat, output logic busy_ok);
        lat     = 2;
        busy_ok = 1'b1;
        for (int c = 1; c <= ncache; c++) begin
            if (!(o_mem_req === 1'b1 && o_ready === 1'b0 && o_valid === 1'b0)) busy_ok = 1'b0;
            i_mem_done  = (c == ncache);
            i_mem_rdata = (c == ncache) ? rdat : 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clk);
            lat++;
        end
        i_mem_done = 1'b0;
        for (int k = 0; k < 20 && o_valid !== 1'b1; k++) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_mem_done = 1'b0; i_mem_rdata = '0;
        i_mem_re = 1'b0; i_mem_we = 1'b0; i_reg_we = 1'b0; i_func3 = '0;
        i_alu_result = '0; i_write_data = '0; i_pc_plus4 = '0; i_pc_target = '0;
        i_imm_ext = '0; i_rd_addr = '0; i_result_src = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_valid, o_mem_req, o_mem_we, o_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0001", {o_valid, o_mem_req, o_mem_we, o_ready});
        end
        checks++;
        if ({o_mem_addr, o_mem_wdata, o_mem_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_mem_port got=%h/%h/%h exp=0", o_mem_addr, o_mem_wdata, o_mem_wstrb);
        end
        checks++;
        if (observed() !== '0) begin
            failures++;
            $display("FAIL reset_memwb got=%h exp=0", observed());
        end
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        exp_t e;
        sb_q.push_back(mk_exp(64'h1234, 64'd0, 5'd7, 1'b1, 1'b0));
        issue(64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7);
        checks++;
        if (o_valid !== 1'b1) begin
            failures++;
            $display("FAIL alu_latency got_valid=%b exp=1", o_valid);
        end
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL alu_payload got=%h exp=%h", observed(), e);
        end
        @(negedge clk);
        checks++;
        if ({o_valid, o_reg_we} !== 2'b00) begin
            failures++;
            $display("FAIL alu_pulse got=%b exp=00", {o_valid, o_reg_we});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb_q.push_back(mk_exp(64'hAAAA_0000_1111_2222, 64'd0, 5'd3, 1'b1, 1'b0));
        sb_q.push_back(mk_exp(64'h5555_FFFF_0000_0008, 64'd0, 5'd30, 1'b0, 1'b0));
        i_alu_result = 64'hAAAA_0000_1111_2222; i_pc_plus4 = i_alu_result + 64'd4;
        i_pc_target = i_alu_result + 64'h100; i_imm_ext = i_alu_result ^ 64'hA5A5;
        i_rd_addr = 5'd3; i_result_src = 3'd3; i_reg_we = 1'b1; i_valid = 1'b1;
        @(negedge clk);
        i_alu_result = 64'h5555_FFFF_0000_0008; i_pc_plus4 = i_alu_result + 64'd4;
        i_pc_target = i_alu_result + 64'h100; i_imm_ext = i_alu_result ^ 64'hA5A5;
        i_rd_addr = 5'd30; i_result_src = 3'd6; i_reg_we = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (o_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL b2b_first got_valid=%b got=%h exp=%h", o_valid, observed(), e);
        end
        @(negedge clk);
        i_valid = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (o_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL b2b_second got_valid=%b got=%h exp=%h", o_valid, observed(), e);
        end
        @(negedge clk);
    endtask

    task automatic test_load_lb();
        exp_t e;
        int lat;
        logic ok;
        sb_q.push_back(mk_exp(64'h8000_1003, 64'hFFFF_FFFF_FFFF_FF80, 5'd9, 1'b1, 1'b0));
        issue(64'h8000_1003, 64'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd9);
        checks++;
        if ({o_mem_addr, o_mem_we, o_mem_wstrb} !== {64'h8000_1000, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL lb_request got=%h/%b/%h exp=80001000/0/00", o_mem_addr, o_mem_we, o_mem_wstrb);
        end
        run_mem(3, 64'h0000_0000_80FF_0000, lat, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL lb_busy got=%b exp=1", ok);
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL lb_latency got=%0d exp=5", lat);
        end
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL lb_data got=%h ready=%b exp=%h", observed(), o_ready, e);
        end
        @(negedge clk);
    endtask

    task automatic test_loads();
        ld_t  tab[$];
        exp_t e;
        int   lat, n;
        logic ok;
        tab.push_back({64'h2000_0004, 3'b110, 64'hF000_0001_1234_5678, 64'h0000_0000_F000_0001});
        tab.push_back({64'h2000_0016, 3'b001, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001});
        tab.push_back({64'h2000_0026, 3'b101, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001});
        tab.push_back({64'h2000_0030, 3'b010, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000});
        tab.push_back({64'h2000_0048, 3'b011, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788});
        tab.push_back({64'h2000_0057, 3'b100, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF});
        tab.push_back({64'h2000_0060, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        tab.push_back({64'h2000_0074, 3'b010, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF});
`ifndef MEMORY_STAGE_MISALIGN_TRAP_EN
        tab.push_back({64'h3000_0003, 3'b011, 64'h1122_3344_5566_7788, 64'h0000_0011_2233_4455});
        tab.push_back({64'h3000_0006, 3'b010, 64'h8899_0000_0000_0000, 64'h0000_0000_0000_8899});
        tab.push_back({64'h3000_0007, 3'b001, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080});
`endif
        foreach (tab[i]) begin
            n = int'($urandom_range(1, 4));
            sb_q.push_back(mk_exp(tab[i].addr, tab[i].expv, 5'(i + 1), 1'b1, 1'b0));
            issue(tab[i].addr, 64'h0, tab[i].f3, 1'b1, 1'b0, 1'b1, 5'(i + 1));
            run_mem(n, tab[i].rdat, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (ok !== 1'b1 || lat != n + 2 || observed() !== e) begin
                failures++;
                $display("FAIL load_%0d busy=%b lat=%0d exp_lat=%0d got=%h exp=%h",
                         i, ok, lat, n + 2, observed(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stores();
        st_t  tab[$];
        exp_t e;
        int   lat;
        logic ok;
        tab.push_back({64'h4000_0006, 3'b001, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000});
        tab.push_back({64'h4000_0015, 3'b000, 64'h1122_3344_5566_77AB, 8'h20, 64'h6677_AB00_0000_0000});
        tab.push_back({64'h4000_0024, 3'b010, 64'h0000_0000_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000});
        tab.push_back({64'h4000_0038, 3'b011, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF});
        tab.push_back({64'h4000_0040, 3'b000, 64'h0000_0000_0000_005A, 8'h01, 64'h0000_0000_0000_005A});
`ifndef MEMORY_STAGE_MISALIGN_TRAP_EN
        tab.push_back({64'h4000_0056, 3'b010, 64'h0000_0000_DEAD_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000});
`endif
        foreach (tab[i]) begin
            sb_q.push_back(mk_exp(tab[i].addr, 64'd0, 5'(i + 10), 1'b0, 1'b0));
            // re and we both set on the first entry: must still be a store
            issue(tab[i].addr, tab[i].wdat, tab[i].f3, (i == 0), 1'b1, 1'b0, 5'(i + 10));
            checks++;
            if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata} !==
                {1'b1, 1'b1, tab[i].addr & ~64'h7, tab[i].strb, tab[i].lane}) begin
                failures++;
                $display("FAIL store_%0d_port got=%b%b/%h/%h/%h exp=11/%h/%h/%h", i, o_mem_req, o_mem_we,
                         o_mem_addr, o_mem_wstrb, o_mem_wdata, tab[i].addr & ~64'h7, tab[i].strb, tab[i].lane);
            end
            run_mem(i + 1, 64'hFFFF_FFFF_FFFF_FFFF, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (ok !== 1'b1 || lat != i + 3 || observed() !== e) begin
                failures++;
                $display("FAIL store_%0d_retire busy=%b lat=%0d exp_lat=%0d got=%h exp=%h",
                         i, ok, lat, i + 3, observed(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_busy();
        int pulses = 0;
        issue(64'h5000_0008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd4);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        checks++;
        if ({o_mem_req, o_ready, o_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rst_busy_state got=%b exp=010", {o_mem_req, o_ready, o_valid});
        end
        // A late done, and a done while IDLE, must both be ignored.
        i_mem_done = 1'b1; i_mem_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        if (o_valid === 1'b1) pulses++;
        @(negedge clk);
        i_mem_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (o_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0 || o_ready !== 1'b1 || o_read_data !== 64'd0) begin
            failures++;
            $display("FAIL rst_busy_drop pulses=%0d ready=%b rdata=%h exp=0/1/0", pulses, o_ready, o_read_data);
        end
    endtask

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    task automatic test_misalign();
        exp_t e;
        int   lat;
        logic ok;
        logic [63:0] addrs [3] = '{64'h6000_0002, 64'h6000_0014, 64'h6000_0021};
        logic [2:0]  f3s   [3] = '{3'b010, 3'b011, 3'b001};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk_exp(addrs[i], 64'd0, 5'd12, 1'b0, 1'b1));
            issue(addrs[i], 64'hFFFF, f3s[i], (i != 1), (i == 1), 1'b1, 5'd12);
            e = sb_q.pop_front();
            checks++;
            if ({o_mem_req, o_valid, o_ready} !== 3'b011 || observed() !== e) begin
                failures++;
                $display("FAIL misalign_%0d req_valid_ready=%b got=%h exp=%h",
                         i, {o_mem_req, o_valid, o_ready}, observed(), e);
            end
            @(negedge clk);
        end
        sb_q.push_back(mk_exp(64'h6000_0032, 64'hFFFF_FFFF_FFFF_8001, 5'd13, 1'b1, 1'b0));
        issue(64'h6000_0032, 64'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd13);
        run_mem(2, 64'h0000_0000_8001_0000, lat, ok);
        e = sb_q.pop_front();
        checks++;
        if (ok !== 1'b1 || lat != 4 || observed() !== e) begin
            failures++;
            $display("FAIL aligned_lh busy=%b lat=%0d exp_lat=4 got=%h exp=%h", ok, lat, observed(), e);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_lb();
        test_loads();
        test_stores();
        test_reset_busy();
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        test_misalign();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
